packed_word_unpacker: RTL and testbench
=======================================

// Module: packed_word_unpacker
// PURPOSE
//   Reader side of packed-struct word assembly: accepts one packed word of
//   NFIELDS equal-width fields and emits the fields one per beat on a
//   valid/ready stream, tagged with declaration index. Field 0 is the
//   most-significant field (first-declared member, e.g. 'high').
//   Sits between a word-wide producer and a field-wide consumer.
// PARAMETERS
//   FIELD_W  8  width of each field in bits (>=1)
//   NFIELDS  2  fields per word (>=2); word width = FIELD_W*NFIELDS
//   IDX_W  localparam = max(1, $clog2(NFIELDS))
// PORTS
//   clk        in   1                 rising-edge clock
//   rst        in   1                 synchronous reset, active-high
//   in_valid   in   1                 in_word/in_lsb_first valid
//   in_ready   out  1                 unpacker can take a word
//   in_word    in   FIELD_W*NFIELDS   packed word; field k at bits
//                                     [W-1-k*FIELD_W -: FIELD_W]
//   in_lsb_first in 1                 1: emit field NFIELDS-1 first
//   out_valid  out  1                 out_field valid
//   out_ready  in   1                 consumer accepts beat
//   out_field  out  FIELD_W           current field value
//   out_idx    out  IDX_W             declaration index of out_field
//   out_last   out  1                 final field of current word
//   words_done out  16                completed words, wraps 16'hFFFF->0
// BEHAVIOUR
//   - Reset (rst=1 at edge): state IDLE, hold reg 0, beat counter 0,
//     words_done 0; out_valid=0, out_field=0, out_idx=0, out_last=0;
//     in_ready=1 in first cycle after reset. Reset mid-word drops the
//     word; no partial beats after reset.
//   - States: IDLE (hold empty), EMIT (hold full, beat counter n).
//   - Accept: in_valid & in_ready at edge -> latch in_word, in_lsb_first,
//     n=0, go EMIT. First beat valid the following cycle (latency 1).
//   - In EMIT: out_valid=1; out_idx = n (msb-first) or NFIELDS-1-n
//     (lsb-first); out_field = hold field[out_idx]; out_last = n==NFIELDS-1.
//     Outputs stable while out_valid & !out_ready.
//   - Beat transfer (out_valid & out_ready): n<NFIELDS-1 -> n+1;
//     n==NFIELDS-1 -> words_done+1, then IDLE unless new word accepted.
//   - in_ready = IDLE | (EMIT & out_last & out_ready): zero-bubble
//     back-to-back; same-edge last-beat and accept -> EMIT, n=0, new word.
//   - in_word/in_lsb_first ignored unless accepted; X on ignored inputs
//     never propagates.
//   - No combinational path in_valid -> out_valid; in_ready depends
//     combinationally on out_ready only.
// TESTING
//   1. FIELD_W=8,NFIELDS=2: word 16'h0203 msb-first, out_ready=1 ->
//      beats (02,idx0,last0),(03,idx1,last1); words_done=1.
//   2. word 16'h0807 lsb-first -> beats (07,idx1,last0),(08,idx0,last1).
//   3. word 16'hAA01, out_ready low 3 cycles on beat 0 -> AA/idx0 held
//      stable 3 cycles, in_ready=0; then AA,01 delivered.
//   4. Back-to-back 16'h0D0D,16'h0506 with in_valid,out_ready=1 ->
//      0D,0D,05,06 on 4 consecutive cycles, in_ready=1 on 2nd beat.
//   5. rst asserted after beat 0 of 16'h1234 -> next cycle out_valid=0,
//      words_done=0, in_ready=1; word 16'h00FF then yields 00,FF only.
//   6. NFIELDS=4: 1000 words with random stalls vs model -> field order
//      exact; words_done=1000; forced wrap 16'hFFFF -> 0.

Source files
------------

// File: rtl/packed_word_unpacker_if.sv
// rtl/packed_word_unpacker_if.sv - word-in / field-out stream bundle for packed_word_unpacker
interface packed_word_unpacker_if #(
    parameter int FIELD_W = 8,
    parameter int NFIELDS = 2
);
    localparam int IDX_W = (NFIELDS <= 2) ? 1 : $clog2(NFIELDS);

    logic                       in_valid;
    logic                       in_ready;
    logic [FIELD_W*NFIELDS-1:0] in_word;
    logic                       in_lsb_first;
    logic                       out_valid;
    logic                       out_ready;
    logic [FIELD_W-1:0]         out_field;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_last;

    modport master (
        output in_valid, in_word, in_lsb_first, out_ready,
        input  in_ready, out_valid, out_field, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, in_lsb_first, out_ready,
        output in_ready, out_valid, out_field, out_idx, out_last
    );
endinterface

// File: rtl/packed_word_unpacker.sv
// rtl/packed_word_unpacker.sv - splits a packed word into one field per beat, tagged with its index
module packed_word_unpacker #(
    parameter int FIELD_W = 8,
    parameter int NFIELDS = 2
) (
    input  logic                clk,
    input  logic                rst,
    packed_word_unpacker_if.slave bus,
    output logic [15:0]         words_done
);
    localparam int W     = FIELD_W * NFIELDS;
    localparam int IDX_W = (NFIELDS <= 2) ? 1 : $clog2(NFIELDS);
    localparam logic [IDX_W-1:0] LAST_N = IDX_W'(NFIELDS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     hold;
    logic             lsb;
    logic [IDX_W-1:0] n;
    logic [15:0]      done_cnt;

    logic             last;
    logic             accept;
    logic             xfer;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     shifted;

    assign last       = (n == LAST_N);
    assign accept     = bus.in_valid & bus.in_ready;
    assign xfer       = bus.out_valid & bus.out_ready;
    assign words_done = done_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input fields are captured only on accept, so ignored inputs never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            lsb      <= 1'b0;
            n        <= '0;
            done_cnt <= '0;
        end else begin
            if (accept) begin
                hold <= bus.in_word;
                lsb  <= bus.in_lsb_first;
                n    <= '0;
            end else if (xfer && !last) begin
                n <= n + 1'b1;
            end
            if (xfer && last) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = EMIT;
            EMIT: if (xfer && last && !bus.in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready looks only at registered state and out_ready, never at in_valid.
    always_comb begin
        bus.out_valid = (state == EMIT);
        bus.in_ready  = (state == IDLE) || ((state == EMIT) && last && bus.out_ready);
        idx           = lsb ? (LAST_N - n) : n;
        shifted       = hold >> (int'(LAST_N - idx) * FIELD_W);
        bus.out_field = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        if (state == EMIT) begin
            bus.out_field = shifted[FIELD_W-1:0];
            bus.out_idx   = idx;
            bus.out_last  = last;
        end
    end
endmodule

// File: tb/tb_packed_word_unpacker.sv
// tb/tb_packed_word_unpacker.sv - directed and scoreboarded checks of packed_word_unpacker
module tb_packed_word_unpacker;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wd2;
    logic [15:0] wd4;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    packed_word_unpacker_if #(.FIELD_W(8), .NFIELDS(2)) bus2 ();
    packed_word_unpacker_if #(.FIELD_W(8), .NFIELDS(4)) bus4 ();

    packed_word_unpacker #(.FIELD_W(8), .NFIELDS(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .words_done(wd2)
    );
    packed_word_unpacker #(.FIELD_W(8), .NFIELDS(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .words_done(wd4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input string tag, input logic [31:0] f, input logic [31:0] i,
                         input logic [31:0] l);
        #1;
        check_eq({tag, "_valid"}, 32'(bus2.out_valid), 32'd1);
        check_eq({tag, "_field"}, 32'(bus2.out_field), f);
        check_eq({tag, "_idx"},   32'(bus2.out_idx),   i);
        check_eq({tag, "_last"},  32'(bus2.out_last),  l);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  exp_f[$];
        logic [1:0]  exp_i[$];
        logic        exp_l[$];
        logic [31:0] w;
        logic [1:0]  ix;
        int          accepted;
        int          done;
        int          cycles;
        bit          offering;

        rst = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_word = '0; bus2.in_lsb_first = 1'b0; bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_word = '0; bus4.in_lsb_first = 1'b0; bus4.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", 32'(bus2.out_valid), 32'd0);
        check_eq("rst_ready", 32'(bus2.in_ready),  32'd1);
        check_eq("rst_field", 32'(bus2.out_field), 32'd0);
        check_eq("rst_idx",   32'(bus2.out_idx),   32'd0);
        check_eq("rst_last",  32'(bus2.out_last),  32'd0);
        check_eq("rst_done",  32'(wd2),            32'd0);
        tick();

        // msb-first word
        bus2.in_valid = 1'b1; bus2.in_word = 16'h0203; bus2.in_lsb_first = 1'b0; bus2.out_ready = 1'b1;
        tick();
        bus2.in_valid = 1'b0; bus2.in_word = 16'hFFFF; bus2.in_lsb_first = 1'b1;
        beat2("t1b0", 32'h02, 32'd0, 32'd0);
        beat2("t1b1", 32'h03, 32'd1, 32'd1);
        #1;
        check_eq("t1_idle", 32'(bus2.out_valid), 32'd0);
        check_eq("t1_done", 32'(wd2), 32'd1);
        tick();

        // lsb-first word
        bus2.in_valid = 1'b1; bus2.in_word = 16'h0807; bus2.in_lsb_first = 1'b1;
        tick();
        bus2.in_valid = 1'b0; bus2.in_lsb_first = 1'b0;
        beat2("t2b0", 32'h07, 32'd1, 32'd0);
        beat2("t2b1", 32'h08, 32'd0, 32'd1);
        #1;
        check_eq("t2_done", 32'(wd2), 32'd2);
        tick();

        // stall on beat 0
        bus2.in_valid = 1'b1; bus2.in_word = 16'hAA01; bus2.in_lsb_first = 1'b0;
        tick();
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t3_hold_valid", 32'(bus2.out_valid), 32'd1);
            check_eq("t3_hold_field", 32'(bus2.out_field), 32'hAA);
            check_eq("t3_hold_idx",   32'(bus2.out_idx),   32'd0);
            check_eq("t3_hold_ready", 32'(bus2.in_ready),  32'd0);
            tick();
        end
        bus2.out_ready = 1'b1;
        beat2("t3b0", 32'hAA, 32'd0, 32'd0);
        beat2("t3b1", 32'h01, 32'd1, 32'd1);
        #1;
        check_eq("t3_done", 32'(wd2), 32'd3);
        tick();

        // back-to-back words, zero bubble
        bus2.in_valid = 1'b1; bus2.in_word = 16'h0D0D;
        tick();
        bus2.in_word = 16'h0506;
        #1;
        check_eq("t4b0_field", 32'(bus2.out_field), 32'h0D);
        check_eq("t4b0_idx",   32'(bus2.out_idx),   32'd0);
        check_eq("t4b0_ready", 32'(bus2.in_ready),  32'd0);
        tick();
        #1;
        check_eq("t4b1_field", 32'(bus2.out_field), 32'h0D);
        check_eq("t4b1_last",  32'(bus2.out_last),  32'd1);
        check_eq("t4b1_ready", 32'(bus2.in_ready),  32'd1);
        tick();
        bus2.in_valid = 1'b0;
        beat2("t4b2", 32'h05, 32'd0, 32'd0);
        beat2("t4b3", 32'h06, 32'd1, 32'd1);
        #1;
        check_eq("t4_done", 32'(wd2), 32'd5);
        tick();

        // reset mid-word
        bus2.in_valid = 1'b1; bus2.in_word = 16'h1234;
        tick();
        bus2.in_valid = 1'b0;
        beat2("t5b0", 32'h12, 32'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(bus2.out_valid), 32'd0);
        check_eq("t5_rst_done",  32'(wd2),            32'd0);
        check_eq("t5_rst_ready", 32'(bus2.in_ready),  32'd1);
        tick();
        bus2.in_valid = 1'b1; bus2.in_word = 16'h00FF;
        tick();
        bus2.in_valid = 1'b0;
        beat2("t5b1", 32'h00, 32'd0, 32'd0);
        beat2("t5b2", 32'hFF, 32'd1, 32'd1);
        #1;
        check_eq("t5_idle", 32'(bus2.out_valid), 32'd0);
        check_eq("t5_done", 32'(wd2), 32'd1);
        tick();

        // NFIELDS=4 scoreboard with random stalls
        accepted = 0; done = 0; cycles = 0; offering = 1'b0;
        while (done < 1000 && cycles < 20000) begin
            if (!offering && accepted < 1000 && $urandom_range(3) != 0) begin
                offering = 1'b1;
                bus4.in_word = $urandom;
                bus4.in_lsb_first = 1'($urandom_range(1));
            end
            bus4.in_valid  = offering;
            bus4.out_ready = ($urandom_range(3) != 0);
            #1;
            if (bus4.out_valid && bus4.out_ready) begin
                check_eq("t6_expected_beat", 32'(exp_f.size() != 0), 32'd1);
                if (exp_f.size() != 0) begin
                    check_eq("t6_field", 32'(bus4.out_field), 32'(exp_f[0]));
                    check_eq("t6_idx",   32'(bus4.out_idx),   32'(exp_i[0]));
                    check_eq("t6_last",  32'(bus4.out_last),  32'(exp_l[0]));
                    if (exp_l[0]) done++;
                    void'(exp_f.pop_front());
                    void'(exp_i.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                w = bus4.in_word;
                for (int k = 0; k < 4; k++) begin
                    ix = bus4.in_lsb_first ? 2'(3 - k) : 2'(k);
                    exp_f.push_back(8'(w >> ((3 - int'(ix)) * 8)));
                    exp_i.push_back(ix);
                    exp_l.push_back(k == 3);
                end
                accepted++;
                offering = 1'b0;
            end
            tick();
            cycles++;
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        check_eq("t6_in_budget", 32'(cycles < 20000), 32'd1);
        #1;
        check_eq("t6_done",  32'(wd4), 32'd1000);
        check_eq("t6_idle",  32'(bus4.out_valid), 32'd0);
        tick();

        // counter wrap
        force dut4.done_cnt = 16'hFFFF;
        tick();
        release dut4.done_cnt;
        #1;
        check_eq("t6_forced", 32'(wd4), 32'hFFFF);
        tick();
        bus4.in_valid = 1'b1; bus4.in_word = 32'h11223344; bus4.in_lsb_first = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        repeat (4) tick();
        #1;
        check_eq("t6_wrap", 32'(wd4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
